sdram_egress_sched: RTL and testbench
=====================================

Name: sdram_egress_sched

Overview:
SDRAM-side scheduler between the multi-queue egress/ingress FIFOs of the wishbone front end and the SDRAM command engine. Arbitrates among per-port egress queues, pops the address word, issues one burst command, streams write data out or routes returned read beats into the matching ingress queue. One transaction in flight at a time.

Parameters:
nr_of_wb_ports, 3, number of wishbone ports/queues (1..8)
adr_width, 30, word address width carried in egress address word bits [35:6]

Ports:
sdram_clk  in  1  clock, all logic rising-edge
sdram_rst  in  1  asynchronous, active-low reset
sdram_fifo_empty  in  [0:nr_of_wb_ports-1]  per-queue egress empty
sdram_fifo_rd_adr  out  1  pop address word
sdram_fifo_rd_data  out  1  pop data word
sdram_fifo_re  out  [0:nr_of_wb_ports-1]  one-hot egress queue select
sdram_dat_i  in  36  egress FIFO q, valid the cycle after a pop
cmd_valid  out  1  command request
cmd_ready  in  1  command accepted
cmd_adr  out  adr_width  burst start word address
cmd_we  out  1  1=write, 0=read
cmd_len  out  5  burst length, 1..16
wr_valid  out  1  write beat valid
wr_ready  in  1  write beat accepted
wr_dat  out  32  write data
wr_sel  out  4  byte enables
rd_valid  in  1  read beat from SDRAM engine
rd_dat  in  32  read beat data
sdram_fifo_wr  out  1  ingress write strobe
sdram_fifo_we  out  [0:nr_of_wb_ports-1]  one-hot ingress queue select
sdram_dat_o  out  32  ingress write data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sdram_rst low, async): state IDLE, all outputs 0, grant register 0, last-grant pointer = port nr_of_wb_ports-1 (port 0 wins first RR round), beat counter 0. Reset mid-transfer abandons it; no partial outputs after release.
- Address word: [35:6] adr, [5] we, [4:3] bte, [2:0] cti. Data word: [35:32] sel, [31:0] data.
- cmd_len: cti==000 or 111 -> 1; else bte 00 -> 1, 01 -> 4, 10 -> 8, 11 -> 16.
- FSM (outputs registered, asserted in the named state):
  IDLE: req = ~sdram_fifo_empty; any req -> latch grant g, go POP.
  POP (1 cycle): sdram_fifo_rd_adr=1, sdram_fifo_re=onehot(g) -> CAP.
  CAP (1 cycle): capture sdram_dat_i into adr/we/len; counter = len -> CMD.
  CMD: cmd_valid=1 with stable cmd_*; hold until cmd_ready. On accept: we=1 -> WPOP, we=0 -> RDATA.
  WPOP: wait while sdram_fifo_empty[g]; else pulse sdram_fifo_rd_data=1, re=onehot(g) one cycle -> WCAP.
  WCAP (1 cycle): capture data word -> WBEAT.
  WBEAT: wr_valid=1 until wr_ready; on accept decrement counter; counter 1->0 -> DONE else WPOP.
  RDATA: each rd_valid cycle -> next cycle sdram_fifo_wr=1, sdram_fifo_we=onehot(g), sdram_dat_o=rd_dat (1-cycle latency); decrement counter; last beat -> DONE. rd_valid outside RDATA ignored.
  DONE (1 cycle): update last-grant pointer = g -> IDLE.
- Minimum: read 1-beat = 5 cycles IDLE->IDLE plus engine latency; write beat rate max 1 per 3 cycles.
- Ingress overflow not checked: ingress queue depth >= 16 by system contract.
- sdram_fifo_re zero except in POP/WPOP pulse; never two bits set.
- Requests arriving while busy wait; queue emptiness re-sampled only in IDLE.

Optional Feature:
SDRAM_SCHED_RR_EN: defined -> round-robin, search starts at last-grant+1 modulo nr_of_wb_ports. Undefined -> fixed priority, lowest-index non-empty port wins; pointer register removed.

Test Plan:
- Reset: drive sdram_rst=0 mid-WBEAT -> all outputs 0 immediately; after release busy=0, first grant goes to port 0.
- Single read port 1: adr word {adr=0x100, we=0, bte=00, cti=000} -> cmd_adr=0x100, cmd_we=0, cmd_len=1; rd_dat=0xDEADBEEF -> next cycle sdram_fifo_wr=1, sdram_fifo_we=010, sdram_dat_o=0xDEADBEEF.
- Write wrap4 port 0: cti=010, bte=01, we=1, four data words sel=F -> cmd_len=4, exactly 4 wr_valid/wr_ready handshakes with matching wr_dat, 5 egress pops total.
- Write data starved: empty[0]=1 after address pop -> FSM holds in WPOP, no rd_data pulse, until empty[0]=0.
- Arbitration (RR on): ports 0,1,2 all non-empty, 1-beat reads -> grants 0,1,2,0; RR off -> 0,0,0 while port 0 stays non-empty.
- Backpressure: cmd_ready low 10 cycles -> cmd_valid and cmd_* stable for 10 cycles, no pops.

Source files
------------

// File: rtl/sdram_egress_sched.sv
// SDRAM egress scheduler: picks a non-empty egress queue, pops its address
// word, issues one burst command, then streams write data from the same queue
// or steers returned read beats into the matching ingress queue.
// One transaction in flight at a time.
// Build option: define SDRAM_SCHED_RR_EN for round-robin arbitration; when it
// is undefined the lowest-index non-empty queue always wins.
module sdram_egress_sched #(
    parameter int nr_of_wb_ports = 3,
    parameter int adr_width      = 30
) (
    input  logic                        sdram_clk,
    input  logic                        sdram_rst,
    input  logic [0:nr_of_wb_ports-1]   sdram_fifo_empty,
    output logic                        sdram_fifo_rd_adr,
    output logic                        sdram_fifo_rd_data,
    output logic [0:nr_of_wb_ports-1]   sdram_fifo_re,
    input  logic [35:0]                 sdram_dat_i,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [adr_width-1:0]        cmd_adr,
    output logic                        cmd_we,
    output logic [4:0]                  cmd_len,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [31:0]                 wr_dat,
    output logic [3:0]                  wr_sel,
    input  logic                        rd_valid,
    input  logic [31:0]                 rd_dat,
    output logic                        sdram_fifo_wr,
    output logic [0:nr_of_wb_ports-1]   sdram_fifo_we,
    output logic [31:0]                 sdram_dat_o,
    output logic                        busy
);

    localparam int GW = (nr_of_wb_ports > 1) ? $clog2(nr_of_wb_ports) : 1;

    typedef enum logic [3:0] {
        IDLE, POP, CAP, CMD, WPOP, WCAP, WBEAT, RDATA, DONE
    } state_t;

    state_t                      state, state_nxt;
    logic [GW-1:0]               grant;
    logic [GW-1:0]               arb_g;
    logic                        arb_hit;
    logic [4:0]                  cnt;
    logic [0:nr_of_wb_ports-1]   pop_re;
    logic                        wpop_fire;
    logic                        ing_wr;

    function automatic logic [0:nr_of_wb_ports-1] onehot(input logic [GW-1:0] idx);
        for (int i = 0; i < nr_of_wb_ports; i++) onehot[i] = (idx == GW'(i));
    endfunction

    // Wrap bursts use the bte length; classic and end-of-burst cycles are single beats.
    function automatic logic [4:0] burst_len(input logic [1:0] bte, input logic [2:0] cti);
        if (cti == 3'b000 || cti == 3'b111) return 5'd1;
        case (bte)
            2'b00:   return 5'd1;
            2'b01:   return 5'd4;
            2'b10:   return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

`ifdef SDRAM_SCHED_RR_EN
    logic [GW-1:0] last_g;

    // Round-robin: search begins one past the port served last.
    always_comb begin
        int idx;
        arb_g   = '0;
        arb_hit = 1'b0;
        idx     = 0;
        for (int k = 1; k <= nr_of_wb_ports; k++) begin
            idx = (int'(last_g) + k) % nr_of_wb_ports;
            if (!arb_hit && !sdram_fifo_empty[idx]) begin
                arb_hit = 1'b1;
                arb_g   = GW'(idx);
            end
        end
    end

    // Remember the served port; reset points at the top port so port 0 wins first.
    always_ff @(posedge sdram_clk or negedge sdram_rst) begin
        if (!sdram_rst) last_g <= GW'(nr_of_wb_ports - 1);
        else if (state == DONE) last_g <= grant;
    end
`else
    // Fixed priority: descending scan leaves the lowest non-empty index.
    always_comb begin
        arb_g   = '0;
        arb_hit = 1'b0;
        for (int i = nr_of_wb_ports - 1; i >= 0; i--) begin
            if (!sdram_fifo_empty[i]) begin
                arb_hit = 1'b1;
                arb_g   = GW'(i);
            end
        end
    end
`endif

    // Next-state decode; the data pop fires in WPOP as soon as the queue has a word.
    always_comb begin
        state_nxt = state;
        wpop_fire = 1'b0;
        case (state)
            IDLE:  if (arb_hit) state_nxt = POP;
            POP:   state_nxt = CAP;
            CAP:   state_nxt = CMD;
            CMD:   if (cmd_ready) state_nxt = cmd_we ? WPOP : RDATA;
            WPOP:  if (!sdram_fifo_empty[grant]) begin
                       wpop_fire = 1'b1;
                       state_nxt = WCAP;
                   end
            WCAP:  state_nxt = WBEAT;
            WBEAT: if (wr_ready) state_nxt = (cnt == 5'd1) ? DONE : WPOP;
            RDATA: if (rd_valid && cnt == 5'd1) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ing_wr             = (state == RDATA) && rd_valid;
    assign sdram_fifo_rd_data = wpop_fire;
    assign sdram_fifo_re      = pop_re | (wpop_fire ? onehot(grant) : '0);

    // State, registered Moore outputs, captured command/data and beat counter.
    always_ff @(posedge sdram_clk or negedge sdram_rst) begin
        if (!sdram_rst) begin
            state             <= IDLE;
            grant             <= '0;
            cnt               <= '0;
            pop_re            <= '0;
            sdram_fifo_rd_adr <= 1'b0;
            cmd_valid         <= 1'b0;
            cmd_adr           <= '0;
            cmd_we            <= 1'b0;
            cmd_len           <= '0;
            wr_valid          <= 1'b0;
            wr_dat            <= '0;
            wr_sel            <= '0;
            sdram_fifo_wr     <= 1'b0;
            sdram_fifo_we     <= '0;
            sdram_dat_o       <= '0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nxt;
            busy              <= (state_nxt != IDLE);
            cmd_valid         <= (state_nxt == CMD);
            wr_valid          <= (state_nxt == WBEAT);
            sdram_fifo_rd_adr <= (state_nxt == POP);
            pop_re            <= (state == IDLE && arb_hit) ? onehot(arb_g) : '0;
            if (state == IDLE && arb_hit) grant <= arb_g;
            if (state == CAP) begin
                cmd_adr <= sdram_dat_i[6 +: adr_width];
                cmd_we  <= sdram_dat_i[5];
                cmd_len <= burst_len(sdram_dat_i[4:3], sdram_dat_i[2:0]);
                cnt     <= burst_len(sdram_dat_i[4:3], sdram_dat_i[2:0]);
            end
            if (state == WCAP) begin
                wr_sel <= sdram_dat_i[35:32];
                wr_dat <= sdram_dat_i[31:0];
            end
            if ((state == WBEAT && wr_ready) || ing_wr) cnt <= cnt - 5'd1;
            // Read beats land in the ingress queue one cycle after the engine offers them.
            sdram_fifo_wr <= ing_wr;
            sdram_fifo_we <= ing_wr ? onehot(grant) : '0;
            if (ing_wr) sdram_dat_o <= rd_dat;
        end
    end

endmodule

// File: tb/tb_sdram_egress_sched.sv
// Scoreboard bench for sdram_egress_sched: egress queue model, read engine
// model, and negedge monitors that pop expected command/write/ingress records.
module tb_sdram_egress_sched;
    localparam int NP = 3;

    logic              sdram_clk = 1'b0;
    logic              sdram_rst = 1'b0;
    logic [0:NP-1]     sdram_fifo_empty = '1;
    logic              sdram_fifo_rd_adr, sdram_fifo_rd_data;
    logic [0:NP-1]     sdram_fifo_re;
    logic [35:0]       sdram_dat_i = '0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b1;
    logic [29:0]       cmd_adr;
    logic              cmd_we;
    logic [4:0]        cmd_len;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [31:0]       wr_dat;
    logic [3:0]        wr_sel;
    logic              rd_valid = 1'b0;
    logic [31:0]       rd_dat = '0;
    logic              sdram_fifo_wr;
    logic [0:NP-1]     sdram_fifo_we;
    logic [31:0]       sdram_dat_o;
    logic              busy;

    sdram_egress_sched #(.nr_of_wb_ports(NP), .adr_width(30)) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .sdram_fifo_empty(sdram_fifo_empty), .sdram_fifo_rd_adr(sdram_fifo_rd_adr),
        .sdram_fifo_rd_data(sdram_fifo_rd_data), .sdram_fifo_re(sdram_fifo_re),
        .sdram_dat_i(sdram_dat_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_adr(cmd_adr), .cmd_we(cmd_we), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat), .wr_sel(wr_sel),
        .rd_valid(rd_valid), .rd_dat(rd_dat), .sdram_fifo_wr(sdram_fifo_wr),
        .sdram_fifo_we(sdram_fifo_we), .sdram_dat_o(sdram_dat_o), .busy(busy)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct packed { logic [29:0] adr; logic we; logic [4:0] len; } cmd_t;
    typedef struct packed { logic [31:0] dat; logic [3:0] sel; } wr_t;
    typedef struct packed { logic [2:0] we; logic [31:0] dat; } ing_t;

    logic [35:0] egq0[$], egq1[$], egq2[$];
    cmd_t        exp_cmd[$];
    wr_t         exp_wr[$];
    ing_t        exp_ing[$];
    logic [31:0] rd_resp[$];

    int checks = 0, errors = 0;
    int cmd_hs = 0, wr_hs = 0, adr_pops = 0, dat_pops = 0;

    function automatic logic [127:0] out_vec();
        return {12'b0, sdram_fifo_rd_adr, sdram_fifo_rd_data, sdram_fifo_re, cmd_valid,
                cmd_adr, cmd_we, cmd_len, wr_valid, wr_dat, wr_sel, sdram_fifo_wr,
                sdram_fifo_we, sdram_dat_o, busy};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Egress queue model: q valid the cycle after a pop; empty follows the queues.
    always @(posedge sdram_clk) begin
        if (sdram_fifo_rd_adr || sdram_fifo_rd_data) begin
            if (sdram_fifo_re[0] && egq0.size() != 0) sdram_dat_i <= egq0.pop_front();
            else if (sdram_fifo_re[1] && egq1.size() != 0) sdram_dat_i <= egq1.pop_front();
            else if (sdram_fifo_re[2] && egq2.size() != 0) sdram_dat_i <= egq2.pop_front();
        end
        sdram_fifo_empty <= {egq0.size() == 0, egq1.size() == 0, egq2.size() == 0};
    end

    // Read engine model: beats start two cycles after an accepted read command.
    initial begin
        forever begin
            @(negedge sdram_clk);
            if (sdram_rst && cmd_valid && cmd_ready && !cmd_we) begin
                int len;
                len = int'(cmd_len);
                @(posedge sdram_clk);
                @(posedge sdram_clk);
                for (int i = 0; i < len; i++) begin
                    #1;
                    rd_valid = 1'b1;
                    rd_dat   = (rd_resp.size() != 0) ? rd_resp.pop_front() : 32'hBAD0BAD0;
                    @(posedge sdram_clk);
                end
                #1 rd_valid = 1'b0;
            end
        end
    end

    // Monitors: compare every handshake against the head of its expected queue.
    always @(negedge sdram_clk) begin
        cmd_t c;
        wr_t  w;
        ing_t g;
        if (sdram_rst) begin
            if (cmd_valid && cmd_ready) begin
                cmd_hs++;
                checks++;
                if (exp_cmd.size() == 0) begin
                    errors++;
                    $display("FAIL cmd unexpected adr=%0h we=%b len=%0d", cmd_adr, cmd_we, cmd_len);
                end else begin
                    c = exp_cmd.pop_front();
                    if ({cmd_adr, cmd_we, cmd_len} !== c) begin
                        errors++;
                        $display("FAIL cmd actual adr=%0h we=%b len=%0d expected adr=%0h we=%b len=%0d",
                                 cmd_adr, cmd_we, cmd_len, c.adr, c.we, c.len);
                    end
                end
            end
            if (wr_valid && wr_ready) begin
                wr_hs++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr unexpected dat=%h sel=%h", wr_dat, wr_sel);
                end else begin
                    w = exp_wr.pop_front();
                    if ({wr_dat, wr_sel} !== w) begin
                        errors++;
                        $display("FAIL wr actual dat=%h sel=%h expected dat=%h sel=%h",
                                 wr_dat, wr_sel, w.dat, w.sel);
                    end
                end
            end
            if (sdram_fifo_wr) begin
                checks++;
                if (exp_ing.size() == 0) begin
                    errors++;
                    $display("FAIL ingress unexpected we=%b dat=%h", sdram_fifo_we, sdram_dat_o);
                end else begin
                    g = exp_ing.pop_front();
                    if (sdram_fifo_we !== g.we || sdram_dat_o !== g.dat) begin
                        errors++;
                        $display("FAIL ingress actual we=%b dat=%h expected we=%b dat=%h",
                                 sdram_fifo_we, sdram_dat_o, g.we, g.dat);
                    end
                end
            end
            if (sdram_fifo_re != '0 || sdram_fifo_rd_adr || sdram_fifo_rd_data) begin
                checks++;
                if (!$onehot(sdram_fifo_re) || (sdram_fifo_rd_adr && sdram_fifo_rd_data)
                    || !(sdram_fifo_rd_adr || sdram_fifo_rd_data)) begin
                    errors++;
                    $display("FAIL pop_select actual re=%b rd_adr=%b rd_data=%b expected one-hot with one strobe",
                             sdram_fifo_re, sdram_fifo_rd_adr, sdram_fifo_rd_data);
                end
            end
            if (sdram_fifo_rd_adr) adr_pops++;
            if (sdram_fifo_rd_data) dat_pops++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sdram_clk);
        #1;
    endtask

    task automatic push_adr(input int p, input logic [29:0] adr, input logic we,
                            input logic [1:0] bte, input logic [2:0] cti);
        logic [35:0] wd;
        wd = {adr, we, bte, cti};
        case (p)
            0: egq0.push_back(wd);
            1: egq1.push_back(wd);
            default: egq2.push_back(wd);
        endcase
    endtask

    task automatic push_dat(input int p, input logic [3:0] sel, input logic [31:0] dat);
        case (p)
            0: egq0.push_back({sel, dat});
            1: egq1.push_back({sel, dat});
            default: egq2.push_back({sel, dat});
        endcase
        exp_wr.push_back({dat, sel});
    endtask

    task automatic exp_c(input logic [29:0] adr, input logic we, input logic [4:0] len);
        exp_cmd.push_back({adr, we, len});
    endtask

    task automatic exp_read(input logic [29:0] adr, input logic [2:0] we, input logic [31:0] dat);
        exp_c(adr, 1'b0, 5'd1);
        rd_resp.push_back(dat);
        exp_ing.push_back({we, dat});
    endtask

    task automatic wait_idle(input string name, input int max);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            @(negedge sdram_clk);
            if (!busy && !rd_valid && exp_cmd.size() == 0 && exp_wr.size() == 0 &&
                exp_ing.size() == 0 && rd_resp.size() == 0 &&
                egq0.size() == 0 && egq1.size() == 0 && egq2.size() == 0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout busy=%b pending cmd=%0d wr=%0d ing=%0d expected all drained",
                     name, busy, exp_cmd.size(), exp_wr.size(), exp_ing.size());
        end
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int p0, h0, d0, n;

        // Reset state
        cyc(3);
        @(negedge sdram_clk);
        check("reset_outputs", out_vec(), 128'd0);
        cyc(1);
        sdram_rst = 1'b1;
        cyc(2);
        check("busy_after_reset", 128'(busy), 128'd0);

        // Single read on port 1
        push_adr(1, 30'h100, 1'b0, 2'b00, 3'b000);
        exp_read(30'h100, 3'b010, 32'hDEADBEEF);
        wait_idle("read_p1", 100);

        // Wrap-4 write on port 0: 1 address + 4 data pops
        p0 = adr_pops + dat_pops;
        h0 = wr_hs;
        push_adr(0, 30'h200, 1'b1, 2'b01, 3'b010);
        exp_c(30'h200, 1'b1, 5'd4);
        push_dat(0, 4'hF, 32'h11111111);
        push_dat(0, 4'hF, 32'h22222222);
        push_dat(0, 4'hF, 32'h33333333);
        push_dat(0, 4'hF, 32'h44444444);
        wait_idle("write_wrap4", 200);
        check("wrap4_pops", 128'(adr_pops + dat_pops - p0), 128'd5);
        check("wrap4_beats", 128'(wr_hs - h0), 128'd4);

        // End-of-burst cti overrides bte: single beat
        push_adr(1, 30'h600, 1'b1, 2'b01, 3'b111);
        exp_c(30'h600, 1'b1, 5'd1);
        push_dat(1, 4'h3, 32'h55AA55AA);
        wait_idle("write_cti111", 100);

        // 16-beat read on port 2
        push_adr(2, 30'h500, 1'b0, 2'b11, 3'b010);
        exp_c(30'h500, 1'b0, 5'd16);
        for (int i = 0; i < 16; i++) begin
            rd_resp.push_back(32'hA0000000 + 32'(i));
            exp_ing.push_back({3'b001, 32'hA0000000 + 32'(i)});
        end
        wait_idle("read16_p2", 300);

        // Starved write data: hold in WPOP until the data word arrives
        h0 = cmd_hs;
        push_adr(0, 30'h700, 1'b1, 2'b00, 3'b000);
        exp_c(30'h700, 1'b1, 5'd1);
        n = 0;
        while (cmd_hs == h0 && n < 50) begin cyc(1); n++; end
        check("starve_cmd_accepted", 128'(cmd_hs - h0), 128'd1);
        d0 = dat_pops;
        cyc(20);
        check("starve_no_data_pop", 128'(dat_pops - d0), 128'd0);
        check("starve_busy_no_wr", 128'({busy, wr_valid}), 128'(2'b10));
        push_dat(0, 4'hC, 32'h0F0F0F0F);
        wait_idle("starve_write", 100);

        // Command backpressure: command held stable, no pops
        cmd_ready = 1'b0;
        push_adr(2, 30'h300, 1'b0, 2'b00, 3'b000);
        exp_read(30'h300, 3'b001, 32'h12345678);
        n = 0;
        while (!cmd_valid && n < 50) begin cyc(1); n++; end
        check("bp_cmd_valid_seen", 128'(cmd_valid), 128'd1);
        p0 = adr_pops + dat_pops;
        for (int i = 0; i < 10; i++) begin
            @(negedge sdram_clk);
            check("bp_cmd_hold", 128'({cmd_valid, cmd_adr, cmd_we, cmd_len}),
                  128'({1'b1, 30'h300, 1'b0, 5'd1}));
        end
        check("bp_no_pops", 128'(adr_pops + dat_pops - p0), 128'd0);
        cyc(1);
        cmd_ready = 1'b1;
        wait_idle("bp_read", 100);

        // Async reset in the middle of a write beat
        wr_ready = 1'b0;
        push_adr(0, 30'h400, 1'b1, 2'b00, 3'b000);
        exp_c(30'h400, 1'b1, 5'd1);
        egq0.push_back({4'hF, 32'hCAFEF00D});
        n = 0;
        while (!wr_valid && n < 50) begin cyc(1); n++; end
        check("rst_wbeat_reached", 128'(wr_valid), 128'd1);
        #2 sdram_rst = 1'b0;
        #1 check("rst_async_outputs", out_vec(), 128'd0);
        cyc(2);
        egq0.delete(); egq1.delete(); egq2.delete();
        exp_cmd.delete(); exp_wr.delete(); exp_ing.delete(); rd_resp.delete();
        wr_ready = 1'b1;
        sdram_rst = 1'b1;
        cyc(2);
        check("rst_release_idle", 128'({busy, wr_valid, cmd_valid}), 128'd0);

        // Arbitration: all ports pending, single-beat reads
        push_adr(0, 30'h010, 1'b0, 2'b00, 3'b000);
        push_adr(0, 30'h011, 1'b0, 2'b00, 3'b000);
        push_adr(0, 30'h012, 1'b0, 2'b00, 3'b000);
        push_adr(1, 30'h020, 1'b0, 2'b00, 3'b000);
        push_adr(2, 30'h030, 1'b0, 2'b00, 3'b000);
`ifdef SDRAM_SCHED_RR_EN
        exp_read(30'h010, 3'b100, 32'hB0000010);
        exp_read(30'h020, 3'b010, 32'hB0000020);
        exp_read(30'h030, 3'b001, 32'hB0000030);
        exp_read(30'h011, 3'b100, 32'hB0000011);
        exp_read(30'h012, 3'b100, 32'hB0000012);
`else
        exp_read(30'h010, 3'b100, 32'hB0000010);
        exp_read(30'h011, 3'b100, 32'hB0000011);
        exp_read(30'h012, 3'b100, 32'hB0000012);
        exp_read(30'h020, 3'b010, 32'hB0000020);
        exp_read(30'h030, 3'b001, 32'hB0000030);
`endif
        wait_idle("arbitration", 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
